// File: rtl/gray_decoder_pipe.sv
// rtl/gray_decoder_pipe.sv - two-stage Gray-to-binary decoder with Hamming step checking
module gray_decoder_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_err,
    output logic [7:0]       err_count
);

    typedef enum logic {UNPRIMED, PRIMED} track_t;

    track_t           state;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_gray;
    logic             s1_err;
    logic [WIDTH-1:0] prev_gray;

    logic             s2_adv;
    logic             accept;
    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic [WIDTH-1:0] bin_next;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    // Clearing the lowest set bit leaves something only when two or more bits differ.
    assign diff      = gray_in ^ prev_gray;
    assign multi_bit = |(diff & (diff - WIDTH'(1)));

    always_comb begin
        bin_next = '0;
        bin_next[WIDTH-1] = s1_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_next[i] = bin_next[i+1] ^ s1_gray[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UNPRIMED;
            s1_valid  <= 1'b0;
            s1_gray   <= '0;
            s1_err    <= 1'b0;
            prev_gray <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            step_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (accept) begin
                s1_gray   <= gray_in;
                s1_err    <= (state == PRIMED) && multi_bit;
                prev_gray <= gray_in;
                state     <= PRIMED;
            end

            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            // Output registers only move when the consumer can take them, holding data stable under stall.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    bin_out  <= bin_next;
                    step_err <= s1_err;
                end
            end

            if (out_valid && out_ready && step_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder_pipe.sv
// tb/tb_gray_decoder_pipe.sv - directed self-checking bench for gray_decoder_pipe
module tb_gray_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] gray_in = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] bin_out;
    logic       step_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_decoder_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .step_err  (step_err),
        .err_count (err_count)
    );

    function automatic logic [3:0] to_gray(input int i);
        return 4'(i ^ (i >> 1));
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        gray_in   = 4'd0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (bin_out !== 4'd0) begin errors++; $display("FAIL reset_bin_out: got %h expected 0", bin_out); end
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err: got %b expected 0", step_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_sequence;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            in_valid = (k < 16);
            gray_in  = to_gray(k % 16);
            cyc();
            if (k == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_latency: got %b expected 0", out_valid); end
            end else if (k <= 16) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== 4'(k - 1) || step_err !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_out%0d: got v=%b bin=%h err=%b expected v=1 bin=%h err=0",
                             k - 1, out_valid, bin_out, step_err, 4'(k - 1));
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL seq_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_single;
        logic [3:0] g_tab [3];
        logic [3:0] b_tab [3];
        g_tab = '{4'b0110, 4'b1000, 4'b1111};
        b_tab = '{4'b0100, 4'b1111, 4'b1010};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            in_valid = 1'b1;
            gray_in  = g_tab[t];
            cyc();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single%0d_early: got %b expected 0", t, out_valid); end
            cyc();
            checks++;
            if (out_valid !== 1'b1 || bin_out !== b_tab[t] || step_err !== 1'b0) begin
                errors++;
                $display("FAIL single%0d: got v=%b bin=%b err=%b expected v=1 bin=%b err=0",
                         t, out_valid, bin_out, step_err, b_tab[t]);
            end
        end
    endtask

    task automatic test_step_err;
        logic [3:0] g_tab [3];
        logic [3:0] b_tab [3];
        logic       e_tab [3];
        g_tab = '{4'b0000, 4'b0011, 4'b0010};
        b_tab = '{4'b0000, 4'b0010, 4'b0011};
        e_tab = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = (k < 3);
            gray_in  = g_tab[k % 3];
            cyc();
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== b_tab[k-1] || step_err !== e_tab[k-1]) begin
                    errors++;
                    $display("FAIL step%0d: got v=%b bin=%b err=%b expected v=1 bin=%b err=%b",
                             k - 1, out_valid, bin_out, step_err, b_tab[k-1], e_tab[k-1]);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL step_err_count: got %0d expected 1", err_count); end
        cyc();
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL step_err_count_final: got %0d expected 1", err_count); end
    endtask

    task automatic test_backpressure;
        logic [3:0] got [$];
        logic       sent;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        gray_in   = 4'b0001;
        cyc();
        gray_in = 4'b0011;
        cyc();
        gray_in = 4'b0010;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || bin_out !== 4'b0001) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b bin=%b expected rdy=0 v=1 bin=0001",
                         k, in_ready, out_valid, bin_out);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (out_valid && out_ready) got.push_back(bin_out);
            sent = in_valid && in_ready;
            cyc();
            if (sent) in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs expected 3", got.size());
        end else if (got[0] !== 4'b0001 || got[1] !== 4'b0010 || got[2] !== 4'b0011) begin
            errors++;
            $display("FAIL bp_order: got %b %b %b expected 0001 0010 0011", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        in_valid = 1'b1;
        gray_in  = 4'b0001;
        cyc();
        gray_in = 4'b0011;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got v=%b rdy=%b expected v=0 rdy=0", out_valid, in_ready);
        end
        cyc();
        rst_n = 1'b1;
        #1;
        in_valid = 1'b1;
        gray_in  = 4'b1111;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_leftover: got %b expected 0", out_valid); end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'b1010 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_sample: got v=%b bin=%b err=%b expected v=1 bin=1010 err=0",
                     out_valid, bin_out, step_err);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1;
            gray_in  = (k % 2 == 0) ? 4'b0000 : 4'b0011;
            cyc();
            if (k == 102) begin
                checks++; if (err_count !== 8'd100) begin errors++; $display("FAIL sat_midway: got %0d expected 100", err_count); end
            end
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", err_count); end
        in_valid = 1'b1;
        gray_in  = 4'b0000;
        repeat (3) cyc();
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", err_count); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_single();
        test_step_err();
        test_backpressure();
        test_reset_midstream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
